// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding, the default byte width and a clog2 helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HDR    = 2'd1,
        ARB_STREAM = 2'd2
    } arb_state_e;

    localparam int DATABITS_DEF = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] index,
    output logic          any
);

    int j;

    // Scan farthest-first so the candidate closest to ptr is written last and wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                index     = PW'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one UART transmitter AXI-Stream port.
// Optional macro UART_ARB_CHID_EN prepends a channel-index header beat to each grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N         = 4,
    parameter int DATABITS  = DATABITS_DEF,
    parameter int MAX_BURST = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*DATABITS-1:0] s_axis_tdata,
    input  logic [N-1:0]          s_axis_tvalid,
    output logic [N-1:0]          s_axis_tready,
    input  logic [N-1:0]          s_axis_tlast,
    output logic [DATABITS-1:0]   m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [N-1:0]          grant,
    output logic                  busy
);

    localparam int PW = clog2(N);
    localparam int CW = clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] gidx_q, gidx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  pick_onehot;
    logic [PW-1:0] pick_idx;
    logic          pick_any;
    logic          hs;

    uart_rr_pick #(.N(N)) u_pick (
        .req    (s_axis_tvalid),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .any    (pick_any)
    );

    // Datapath is a pure mux on the granted lane; nothing is buffered.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (state_q)
            ARB_STREAM: begin
                m_axis_tdata          = s_axis_tdata[int'(gidx_q)*DATABITS +: DATABITS];
                m_axis_tvalid         = s_axis_tvalid[gidx_q];
                m_axis_tlast          = s_axis_tlast[gidx_q] | (cnt_q == LAST_CNT);
                s_axis_tready[gidx_q] = m_axis_tready;
            end
`ifdef UART_ARB_CHID_EN
            ARB_HDR: begin
                m_axis_tdata  = DATABITS'(gidx_q);
                m_axis_tvalid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign hs = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
`ifdef UART_ARB_CHID_EN
                    state_d = ARB_HDR;
`else
                    state_d = ARB_STREAM;
`endif
                end
            end
`ifdef UART_ARB_CHID_EN
            ARB_HDR: begin
                if (hs) state_d = ARB_STREAM;
            end
`endif
            ARB_STREAM: begin
                if (hs) begin
                    cnt_d = cnt_q + 1'b1;
                    // m_axis_tlast already folds in the forced MAX_BURST release.
                    if (m_axis_tlast) begin
                        ptr_d   = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N=4, DATABITS=8, MAX_BURST=4).
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N-1:0]  s_tvalid = '0;
    logic [N-1:0]  s_tready;
    logic [N-1:0]  s_tlast = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [N-1:0]  grant;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(.N(N), .DATABITS(DW), .MAX_BURST(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Full beat view and control-only view of the DUT outputs.
    function automatic logic [18:0] obs();
        return {grant, busy, m_tvalid, m_tlast, m_tdata, s_tready};
    endfunction
    function automatic logic [9:0] ctl();
        return {grant, busy, m_tvalid, s_tready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int r, input logic v, input logic [7:0] d, input logic l);
        s_tvalid[r]          = v;
        s_tdata[r*DW +: DW]  = d;
        s_tlast[r]           = l;
    endtask

    task automatic test_reset();
        put(0, 1'b1, 8'h55, 1'b0);
        #3;
        n_cmp++;
        if ({ctl(), m_tlast} !== 11'b0) begin
            n_err++; $display("FAIL reset_early: got %h want %h", {ctl(), m_tlast}, 11'b0);
        end
        tick(); tick();
        n_cmp++;
        if ({ctl(), m_tlast} !== 11'b0) begin
            n_err++; $display("FAIL reset_held: got %h want %h", {ctl(), m_tlast}, 11'b0);
        end
        put(0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        #2;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL reset_release: got %h want %h", ctl(), 10'b0);
        end
    endtask

    task automatic test_single();
        logic [7:0]  bytes [3] = '{8'h11, 8'h22, 8'h33};
        logic [18:0] e;
        tick();
        put(0, 1'b1, bytes[0], 1'b0);
        #2;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL single_idle: got %h want %h", ctl(), 10'b0);
        end
        for (int b = 0; b < 3; b++) begin
            tick();
            if (b > 0) put(0, 1'b1, bytes[b], b == 2);
            #2;
            e = {4'b0001, 1'b1, 1'b1, (b == 2), bytes[b], 4'b0001};
            n_cmp++;
            if (obs() !== e) begin
                n_err++; $display("FAIL single_beat%0d: got %h want %h", b, obs(), e);
            end
        end
        tick();
        put(0, 1'b0, 8'h00, 1'b0);
        #2;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL single_release: got %h want %h", ctl(), 10'b0);
        end
    endtask

    task automatic test_rr();
        logic [18:0] e;
        logic [3:0]  oh;
        tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < N; i++) put(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
        #1;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL rr_idle: got %h want %h", ctl(), 10'b0);
        end
        for (int k = 0; k < N; k++) begin
            tick();
            #2;
            oh = 4'(1 << k);
            e  = {oh, 1'b1, 1'b1, 1'b1, 8'hA0 + 8'(k), oh};
            n_cmp++;
            if (obs() !== e) begin
                n_err++; $display("FAIL rr_grant%0d: got %h want %h", k, obs(), e);
            end
            tick();
            put(k, 1'b0, 8'h00, 1'b0);
            #2;
            n_cmp++;
            if (ctl() !== 10'b0) begin
                n_err++; $display("FAIL rr_gap%0d: got %h want %h", k, ctl(), 10'b0);
            end
        end
        // After serving requester 3 the pointer has wrapped to 0.
        put(3, 1'b1, 8'hB3, 1'b1);
        put(0, 1'b1, 8'hB0, 1'b1);
        tick();
        #2;
        n_cmp++;
        if (ctl() !== {4'b0001, 1'b1, 1'b1, 4'b0001}) begin
            n_err++; $display("FAIL rr_wrap: got %h want %h", ctl(), {4'b0001, 1'b1, 1'b1, 4'b0001});
        end
        tick();
        put(0, 1'b0, 8'h00, 1'b0);
        put(3, 1'b0, 8'h00, 1'b0);
        #2;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL rr_done: got %h want %h", ctl(), 10'b0);
        end
    endtask

    task automatic test_burst();
        logic [7:0]  bytes [6] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        logic [18:0] e;
        tick();
        put(2, 1'b1, bytes[0], 1'b0);
        #2;
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b > 0) put(2, 1'b1, bytes[b], 1'b0);
            #2;
            e = {4'b0100, 1'b1, 1'b1, (b == 3), bytes[b], 4'b0100};
            n_cmp++;
            if (obs() !== e) begin
                n_err++; $display("FAIL burst_beat%0d: got %h want %h", b, obs(), e);
            end
        end
        tick();
        put(2, 1'b1, bytes[4], 1'b0);
        #2;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL burst_release: got %h want %h", ctl(), 10'b0);
        end
        for (int b = 4; b < 6; b++) begin
            tick();
            if (b > 4) put(2, 1'b1, bytes[b], 1'b1);
            #2;
            e = {4'b0100, 1'b1, 1'b1, (b == 5), bytes[b], 4'b0100};
            n_cmp++;
            if (obs() !== e) begin
                n_err++; $display("FAIL burst_regrant%0d: got %h want %h", b, obs(), e);
            end
        end
        tick();
        put(2, 1'b0, 8'h00, 1'b0);
        #2;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL burst_done: got %h want %h", ctl(), 10'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  bytes [3] = '{8'h71, 8'h72, 8'h73};
        logic        pat [12] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
        logic [18:0] e;
        int          idx;
        logic        hs;
        idx = 0;
        hs  = 1'b0;
        tick();
        put(1, 1'b1, bytes[0], 1'b0);
        #2;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (hs) begin
                idx++;
                if (idx == 3) break;
                put(1, 1'b1, bytes[idx], idx == 2);
            end
            m_tready = pat[c];
            #2;
            e = {4'b0010, 1'b1, 1'b1, (idx == 2), bytes[idx], (pat[c] ? 4'b0010 : 4'b0000)};
            n_cmp++;
            if (obs() !== e) begin
                n_err++; $display("FAIL bp_cycle%0d: got %h want %h", c, obs(), e);
            end
            hs = pat[c];
        end
        put(1, 1'b0, 8'h00, 1'b0);
        m_tready = 1'b1;
        #2;
        n_cmp++;
        if ({ctl(), idx} !== {10'b0, 32'd3}) begin
            n_err++; $display("FAIL bp_done: got ctl %h beats %0d want ctl 0 beats 3", ctl(), idx);
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] e;
        tick();
        put(2, 1'b1, 8'h81, 1'b0);
        tick();
        #2;
        e = {4'b0100, 1'b1, 1'b1, 1'b0, 8'h81, 4'b0100};
        n_cmp++;
        if (obs() !== e) begin
            n_err++; $display("FAIL rstmid_beat0: got %h want %h", obs(), e);
        end
        tick();
        put(2, 1'b1, 8'h82, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ctl(), m_tlast} !== 11'b0) begin
            n_err++; $display("FAIL rstmid_abort: got %h want %h", {ctl(), m_tlast}, 11'b0);
        end
        put(1, 1'b1, 8'h91, 1'b1);
        tick();
        rst = 1'b0;
        #2;
        // Pointer back at 0 picks requester 1 ahead of requester 2.
        tick();
        #2;
        e = {4'b0010, 1'b1, 1'b1, 1'b1, 8'h91, 4'b0010};
        n_cmp++;
        if (obs() !== e) begin
            n_err++; $display("FAIL rstmid_restart: got %h want %h", obs(), e);
        end
        tick();
        put(1, 1'b0, 8'h00, 1'b0);
        put(2, 1'b0, 8'h00, 1'b0);
        #2;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL rstmid_done: got %h want %h", ctl(), 10'b0);
        end
    endtask

    task automatic test_chid();
        logic [18:0] e;
        tick();
        put(3, 1'b1, 8'hA5, 1'b1);
        tick();
        #2;
`ifdef UART_ARB_CHID_EN
        e = {4'b1000, 1'b1, 1'b1, 1'b0, 8'h03, 4'b0000};
        n_cmp++;
        if (obs() !== e) begin
            n_err++; $display("FAIL chid_header: got %h want %h", obs(), e);
        end
        tick();
        #2;
`endif
        e = {4'b1000, 1'b1, 1'b1, 1'b1, 8'hA5, 4'b1000};
        n_cmp++;
        if (obs() !== e) begin
            n_err++; $display("FAIL chid_data: got %h want %h", obs(), e);
        end
        tick();
        put(3, 1'b0, 8'h00, 1'b0);
        #2;
        n_cmp++;
        if (ctl() !== 10'b0) begin
            n_err++; $display("FAIL chid_done: got %h want %h", ctl(), 10'b0);
        end
    endtask

    initial begin
        test_reset();
`ifndef UART_ARB_CHID_EN
        test_single();
        test_rr();
        test_burst();
        test_backpressure();
        test_reset_mid();
`endif
        test_chid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
